id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline register for the 5-stage 64-bit pipeline, sitting directly upstream of the forwarding unit. It latches decoded operands, register numbers and control signals from decode each cycle. It supplies the forwarding unit's ALU operand values and source register numbers. It detects load-use hazards, stalls the front end, and inserts bubbles, with flush and downstream-hold support.

Parameters:
DATA_W, 64, operand/immediate width
REG_W, 5, register number width
CTRL_W, 8, opaque ALU/branch control bundle width
ZERO_REG, 31, hardwired-zero register (XZR); never a hazard source

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
id_valid  input  1  decode slot holds a real instruction
id_rs1  input  REG_W  source register A number
id_rs2  input  REG_W  source register B number
id_use_rs1  input  1  instruction reads rs1
id_use_rs2  input  1  instruction reads rs2
id_rd  input  REG_W  destination register
id_rdata1  input  DATA_W  register file read A
id_rdata2  input  DATA_W  register file read B
id_imm  input  DATA_W  sign-extended immediate
id_ctrl  input  CTRL_W  control bundle
id_mem_read  input  1  instruction is a load
id_reg_write  input  1  instruction writes rd
flush  input  1  branch resolved taken; kill ID/EX contents
ex_hold  input  1  downstream not ready; freeze stage
stall  output  1  freeze PC and IF/ID this cycle
ex_valid  output  1  registered valid
ex_rs1, ex_rs2  output  REG_W  to forwarding unit A/B register-number inputs
ex_rd  output  REG_W  destination, becomes EX/MEM pipe register number
ex_rdata1, ex_rdata2  output  DATA_W  to forwarding unit A/B operand inputs
ex_imm  output  DATA_W  registered immediate
ex_ctrl  output  CTRL_W  registered control
ex_mem_read, ex_reg_write  output  1  registered load / write-enable flags
stall_count  output  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset (rst=1 at clk edge): all ex_* outputs go to 0, and stall_count goes to 0. stall is combinational and evaluates to 0 out of reset, because ex_mem_read=0.
- load_use = ex_valid & ex_mem_read & ex_reg_write & (ex_rd != ZERO_REG) & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- stall = ex_hold | (load_use & ~flush). Combinational, with no added latency.
- Register update priority per edge: rst > flush > ex_hold > load_use > normal load.
  - flush: bubble (ex_valid, ex_mem_read, ex_reg_write = 0; ex_ctrl = 0; data fields don't-care, driven 0).
  - ex_hold without flush: all ex_* registers keep their value.
  - load_use: bubble. Decode is held by stall and re-presents the same instruction next cycle.
  - normal: capture all id_* inputs. ex_valid = id_valid. ex_mem_read and ex_reg_write are ANDed with id_valid.
- A load-use stall lasts exactly one cycle. After the bubble, ex_mem_read=0, so load_use clears and the dependent instruction enters next edge.
- Back-to-back loads with dependency chains each produce their own single bubble.
- Dependency on ZERO_REG never stalls. An invalid ID slot never stalls.
- flush together with load_use: no stall. The bubble is inserted, and upstream flush handling owns the IF/ID kill.
- flush together with ex_hold: flush wins and the stage becomes a bubble. stall remains 1 due to ex_hold.
- rst asserted mid-stall or mid-hold: cleared next edge. No residual stall.

Optional Feature:
STALL_CNT_EN:
- Defined: stall_count increments by 1 on each edge where rst=0 and stall=1. It wraps from 0xFFFFFFFF to 0 and is cleared by rst.
- Undefined: the counter logic is not compiled and stall_count is tied to 0. The port list is unchanged.

Test Plan:
- Reset then load: rst 2 cycles; id_rdata1=0xAAAA_AAAA_AAAA_AAAA, id_rs1=1, id_valid=1 -> after one edge ex_rdata1=0xAAAA...AAAA, ex_rs1=1, stall=0 throughout.
- Load-use on rs2: cycle N captures a load (mem_read=1, reg_write=1, rd=2). Decode then holds rs2=2, use_rs2=1 -> stall=1 for exactly 1 cycle, ex_valid=0 next edge, and the dependent instruction is captured the edge after. stall_count=1 if STALL_CNT_EN.
- No hazard cases: a load with rd=31 followed by a consumer of rs1=31 -> stall=0. A load rd=3 followed by rs1=3 with use_rs1=0 -> stall=0. A non-load rd=2 followed by rs2=2 -> stall=0, normal capture (the forwarding unit handles it).
- Flush priority: the load_use condition and flush=1 in the same cycle -> stall=0, ex_valid=0, ex_reg_write=0 after the edge.
- Hold: with ex_rd=5 and ex_rdata2=0xBBBB..., assert ex_hold 3 cycles with changing id_* inputs -> ex_* unchanged, stall=1 for 3 cycles. Release -> new capture.
- Reset mid-stall, plus wrap: rst during a load-use stall -> all ex_*=0, stall=0 next cycle. Preload stall_count near 0xFFFFFFFF (force) and stall twice -> value 0x00000000 then 0x00000001.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection.
// Sits in front of the forwarding unit. It turns a load-use dependency into a
// single-cycle front-end stall plus a bubble. It also supports flush (the
// stage is killed) and ex_hold (the stage is frozen).
// Optional build macro STALL_CNT_EN: when defined, stall_count counts stall
// cycles. When it is not defined, stall_count is tied to zero.
module id_ex_stage #(
  parameter int DATA_W   = 64,
  parameter int REG_W    = 5,
  parameter int CTRL_W   = 8,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall,
  output logic              ex_valid,
  output logic [REG_W-1:0]  ex_rs1,
  output logic [REG_W-1:0]  ex_rs2,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic [31:0]       stall_count
);

  localparam logic [REG_W-1:0] ZERO_R = REG_W'(ZERO_REG);

  logic              valid_q, valid_d;
  logic [REG_W-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d, imm_q, imm_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              mem_read_q, mem_read_d, reg_write_q, reg_write_d;
  logic              load_use;

  // The load in EX would feed the instruction in decode before its data exists.
  // XZR is never a real producer, and an empty decode slot consumes nothing.
  always_comb begin
    load_use = valid_q & mem_read_q & reg_write_q & (rd_q != ZERO_R) & id_valid &
               ((id_use_rs1 & (id_rs1 == rd_q)) | (id_use_rs2 & (id_rs2 == rd_q)));
    // A flush kills the fetch path upstream, so a load-use freeze is pointless.
    stall = ex_hold | (load_use & ~flush);
  end

  // Next-state selection: flush > hold > load-use bubble > normal capture.
  always_comb begin
    valid_d     = valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    rdata1_d    = rdata1_q;
    rdata2_d    = rdata2_q;
    imm_d       = imm_q;
    ctrl_d      = ctrl_q;
    mem_read_d  = mem_read_q;
    reg_write_d = reg_write_q;
    if (flush || (!ex_hold && load_use)) begin
      // Bubble: the data fields are don't-care and are driven to zero.
      valid_d     = 1'b0;
      rs1_d       = '0;
      rs2_d       = '0;
      rd_d        = '0;
      rdata1_d    = '0;
      rdata2_d    = '0;
      imm_d       = '0;
      ctrl_d      = '0;
      mem_read_d  = 1'b0;
      reg_write_d = 1'b0;
    end else if (!ex_hold) begin
      valid_d     = id_valid;
      rs1_d       = id_rs1;
      rs2_d       = id_rs2;
      rd_d        = id_rd;
      rdata1_d    = id_rdata1;
      rdata2_d    = id_rdata2;
      imm_d       = id_imm;
      ctrl_d      = id_ctrl;
      mem_read_d  = id_mem_read & id_valid;
      reg_write_d = id_reg_write & id_valid;
    end
  end

  // Pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rdata1_q    <= '0;
      rdata2_q    <= '0;
      imm_q       <= '0;
      ctrl_q      <= '0;
      mem_read_q  <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rdata1_q    <= rdata1_d;
      rdata2_q    <= rdata2_d;
      imm_q       <= imm_d;
      ctrl_q      <= ctrl_d;
      mem_read_q  <= mem_read_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_rs1       = rs1_q;
  assign ex_rs2       = rs2_q;
  assign ex_rd        = rd_q;
  assign ex_rdata1    = rdata1_q;
  assign ex_rdata2    = rdata2_q;
  assign ex_imm       = imm_q;
  assign ex_ctrl      = ctrl_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_reg_write = reg_write_q;

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Free-running stall-cycle counter. It wraps naturally and is cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed test-plan scenarios plus randomized traffic for
// id_ex_stage. A behavioural model of the EX-side instruction slot predicts
// every output.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_use_rs1, id_use_rs2, id_mem_read, id_reg_write;
  logic        flush, ex_hold;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [63:0] id_rdata1, id_rdata2, id_imm;
  logic [7:0]  id_ctrl;
  logic        stall, ex_valid, ex_mem_read, ex_reg_write;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [63:0] ex_rdata1, ex_rdata2, ex_imm;
  logic [7:0]  ex_ctrl;
  logic [31:0] stall_count;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_mem_read(id_mem_read), .id_reg_write(id_reg_write), .flush(flush),
    .ex_hold(ex_hold), .stall(stall), .ex_valid(ex_valid), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
    .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .stall_count(stall_count)
  );

`ifdef STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // Model of the instruction occupying EX. All zeros means an empty slot.
  typedef struct packed {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] d1, d2, imm;
    logic [7:0]  ctrl;
    logic        mr, rw;
  } slot_t;

  slot_t       m;
  logic [31:0] m_cnt;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic        last_stall;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, wanted %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // The instruction in decode needs the result of a load that is still in EX.
  function automatic logic model_hazard();
    logic needs;
    needs = (id_use_rs1 && id_rs1 == m.rd) || (id_use_rs2 && id_rs2 == m.rd);
    return m.v && m.mr && m.rw && (m.rd != 5'd31) && id_valid && needs;
  endfunction

  // One clock: check stall before the edge, advance the model, check the registers after the edge.
  task automatic step();
    logic  hz, exp_stall;
    slot_t nxt;
    #3;
    hz        = model_hazard();
    exp_stall = ex_hold || (hz && !flush);
    chk("stall", {63'd0, stall}, {63'd0, exp_stall});
    if (rst) begin
      nxt   = '0;
      m_cnt = 32'd0;
    end else begin
      if (CNT_EN && exp_stall) m_cnt = m_cnt + 32'd1;
      if (flush) nxt = '0;
      else if (ex_hold) nxt = m;
      else if (hz) nxt = '0;
      else nxt = '{v: id_valid, rs1: id_rs1, rs2: id_rs2, rd: id_rd, d1: id_rdata1,
                   d2: id_rdata2, imm: id_imm, ctrl: id_ctrl,
                   mr: id_mem_read && id_valid, rw: id_reg_write && id_valid};
    end
    last_stall = exp_stall;
    @(posedge clk);
    #1;
    m = nxt;
    cyc++;
    chk("ex_valid", {63'd0, ex_valid}, {63'd0, m.v});
    chk("ex_rs1", {59'd0, ex_rs1}, {59'd0, m.rs1});
    chk("ex_rs2", {59'd0, ex_rs2}, {59'd0, m.rs2});
    chk("ex_rd", {59'd0, ex_rd}, {59'd0, m.rd});
    chk("ex_rdata1", ex_rdata1, m.d1);
    chk("ex_rdata2", ex_rdata2, m.d2);
    chk("ex_imm", ex_imm, m.imm);
    chk("ex_ctrl", {56'd0, ex_ctrl}, {56'd0, m.ctrl});
    chk("ex_mem_read", {63'd0, ex_mem_read}, {63'd0, m.mr});
    chk("ex_reg_write", {63'd0, ex_reg_write}, {63'd0, m.rw});
    chk("stall_count", {32'd0, stall_count}, {32'd0, m_cnt});
    $display("cyc %0d rst=%0b flush=%0b hold=%0b stall=%0b -> ex_valid=%0b rd=%0d mr=%0b rw=%0b cnt=%0d",
             cyc, rst, flush, ex_hold, exp_stall, ex_valid, ex_rd, ex_mem_read, ex_reg_write, stall_count);
  endtask

  task automatic put(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd,
                     input logic mr, input logic rw);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_mem_read = mr; id_reg_write = rw;
    id_rdata1 = {$urandom, $urandom}; id_rdata2 = {$urandom, $urandom};
    id_imm = {$urandom, $urandom}; id_ctrl = 8'($urandom);
  endtask

  function automatic logic [4:0] pick_reg();
    logic [4:0] regs [5];
    regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd2; regs[3] = 5'd3; regs[4] = 5'd31;
    return regs[$urandom_range(0, 4)];
  endfunction

  initial begin
    m = '0; m_cnt = 32'd0; last_stall = 1'b0;
    rst = 1'b1; flush = 1'b0; ex_hold = 1'b0;

    // Reset then load.
    put(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b0, 1'b1);
    id_rdata1 = 64'hAAAA_AAAA_AAAA_AAAA;
    step(); step();
    rst = 1'b0;
    step();
    chk("tp_rdata1", ex_rdata1, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("tp_rs1", {59'd0, ex_rs1}, 64'd1);

    // Load-use on rs2: exactly one stall, a bubble, then the consumer enters.
    put(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1); step();
    put(1'b1, 5'd7, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1);
    step();
    chk("lu_stalled", {63'd0, last_stall}, 64'd1);
    chk("lu_bubble", {63'd0, ex_valid}, 64'd0);
    step();
    chk("lu_one_cycle", {63'd0, last_stall}, 64'd0);
    chk("lu_enter", {59'd0, ex_rd}, 64'd8);

    // No hazard: XZR target, an unused source, and a non-load producer.
    put(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b1); step();
    put(1'b1, 5'd31, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b1); step();
    chk("xzr_nostall", {63'd0, last_stall}, 64'd0);
    put(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1); step();
    put(1'b1, 5'd3, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1); step();
    chk("nouse_nostall", {63'd0, last_stall}, 64'd0);
    put(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b1); step();
    put(1'b1, 5'd0, 5'd2, 1'b0, 1'b1, 5'd10, 1'b0, 1'b1); step();
    chk("alu_nostall", {63'd0, last_stall}, 64'd0);
    chk("alu_capture", {59'd0, ex_rd}, 64'd10);

    // Flush together with a load-use condition.
    put(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1); step();
    put(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b0, 1'b1);
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_nostall", {63'd0, last_stall}, 64'd0);
    chk("flush_rw", {63'd0, ex_reg_write}, 64'd0);

    // Hold for three cycles while the decode inputs keep changing, then release.
    put(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b1);
    id_rdata2 = 64'hBBBB_BBBB_BBBB_BBBB; step();
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put(1'b1, pick_reg(), pick_reg(), 1'b1, 1'b1, pick_reg(), 1'b1, 1'b1);
      step();
      chk("hold_rdata2", ex_rdata2, 64'hBBBB_BBBB_BBBB_BBBB);
      chk("hold_stall", {63'd0, last_stall}, 64'd1);
    end
    ex_hold = 1'b0;
    put(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b0, 1'b1); step();
    chk("release_rd", {59'd0, ex_rd}, 64'd12);

    // Reset in the middle of a load-use stall.
    put(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1); step();
    put(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    #3;
    chk("rst_clear_stall", {63'd0, stall}, 64'd0);
    step();

`ifdef STALL_CNT_EN
    // Counter wrap: preload the counter to all ones, then stall twice.
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    ex_hold = 1'b1;
    step();
    chk("wrap0", {32'd0, stall_count}, 64'd0);
    step();
    chk("wrap1", {32'd0, stall_count}, 64'd1);
    ex_hold = 1'b0;
`endif

    // Randomized traffic. The front end re-presents the same instruction while stalled.
    for (int i = 0; i < 400; i++) begin
      if (!last_stall)
        put($urandom_range(0, 7) != 0, pick_reg(), pick_reg(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, pick_reg(),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 49) == 0);
      flush   = ($urandom_range(0, 9) == 0);
      ex_hold = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
